// File: rtl/lsu_pkg.sv
// Shared types and default widths for the load/store memory master.
package lsu_pkg;

  localparam int unsigned LSU_DATA_W   = 32;
  localparam int unsigned LSU_ADDR_W   = 32;
  localparam int unsigned LSU_ADDR_MAX = 65535;
  localparam int unsigned PERF_W       = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2,
    RESP  = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_perf_cnt.sv
// Wrapping event counters for accepted loads, stores and out-of-range requests.
// Only built when LSU_PERF_CNT_EN is defined.
`ifdef LSU_PERF_CNT_EN
module lsu_perf_cnt
  import lsu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              inc_load,
  input  logic              inc_store,
  input  logic              inc_err,
  output logic [PERF_W-1:0] perf_loads,
  output logic [PERF_W-1:0] perf_stores,
  output logic [PERF_W-1:0] perf_errs
);

  logic [PERF_W-1:0] loads_q;
  logic [PERF_W-1:0] stores_q;
  logic [PERF_W-1:0] errs_q;

  // Plain binary counters; overflow wraps to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      loads_q  <= '0;
      stores_q <= '0;
      errs_q   <= '0;
    end else begin
      if (inc_load)  loads_q  <= loads_q  + PERF_W'(1);
      if (inc_store) stores_q <= stores_q + PERF_W'(1);
      if (inc_err)   errs_q   <= errs_q   + PERF_W'(1);
    end
  end

  assign perf_loads  = loads_q;
  assign perf_stores = stores_q;
  assign perf_errs   = errs_q;

endmodule
`endif

// File: rtl/lsu_mem_master.sv
// Single-outstanding load/store master driving a word-addressed combinational memory.
// Optional LSU_PERF_CNT_EN adds perf_loads/perf_stores/perf_errs event counters.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_W   = LSU_DATA_W,
  parameter int unsigned ADDR_W   = LSU_ADDR_W,
  parameter int unsigned ADDR_MAX = LSU_ADDR_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_read_address,
  output logic [ADDR_W-1:0] mem_write_address,
  output logic              mem_write_enable,
  output logic [DATA_W-1:0] mem_data_in,
`ifdef LSU_PERF_CNT_EN
  output logic [PERF_W-1:0] perf_loads,
  output logic [PERF_W-1:0] perf_stores,
  output logic [PERF_W-1:0] perf_errs,
`endif
  input  logic [DATA_W-1:0] mem_data_out
);

  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(ADDR_MAX);

  lsu_state_e        state_q,    state_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q,  rsp_data_d;
  logic              rsp_err_q,   rsp_err_d;
  logic [ADDR_W-1:0] rd_addr_q,   rd_addr_d;
  logic [ADDR_W-1:0] wr_addr_q,   wr_addr_d;
  logic              we_q,        we_d;
  logic [DATA_W-1:0] wdata_q,     wdata_d;
  logic              addr_err_c;

  assign addr_err_c = (req_addr > ADDR_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      rd_addr_q   <= '0;
      wr_addr_q   <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      rd_addr_q   <= rd_addr_d;
      wr_addr_q   <= wr_addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
    end
  end

  // Write strobe defaults low so it can only be high for the single STORE cycle.
  always_comb begin
    state_d     = state_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    rd_addr_d   = rd_addr_q;
    wr_addr_d   = wr_addr_q;
    we_d        = 1'b0;
    wdata_d     = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (addr_err_c) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = '0;
            rsp_err_d   = 1'b1;
            state_d     = RESP;
          end else if (req_we) begin
            wr_addr_d = req_addr;
            wdata_d   = req_wdata;
            we_d      = 1'b1;
            state_d   = STORE;
          end else begin
            rd_addr_d = req_addr;
            state_d   = LOAD;
          end
        end
      end
      LOAD: begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = mem_data_out;
        rsp_err_d   = 1'b0;
        state_d     = RESP;
      end
      STORE: begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = '0;
        rsp_err_d   = 1'b0;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready         = (state_q == IDLE);
  assign rsp_valid         = rsp_valid_q;
  assign rsp_data          = rsp_data_q;
  assign rsp_err           = rsp_err_q;
  assign mem_read_address  = rd_addr_q;
  assign mem_write_address = wr_addr_q;
  assign mem_write_enable  = we_q;
  assign mem_data_in       = wdata_q;

`ifdef LSU_PERF_CNT_EN
  logic accept_c;
  assign accept_c = (state_q == IDLE) && req_valid;

  lsu_perf_cnt u_perf_cnt (
    .clk         (clk),
    .rst         (rst),
    .inc_load    (accept_c && !addr_err_c && !req_we),
    .inc_store   (accept_c && !addr_err_c &&  req_we),
    .inc_err     (accept_c &&  addr_err_c),
    .perf_loads  (perf_loads),
    .perf_stores (perf_stores),
    .perf_errs   (perf_errs)
  );
`endif

endmodule

// File: tb/tb_lsu_mem_master.sv
// Scoreboard bench for lsu_mem_master with a behavioural memory and reference model.
module tb_lsu_mem_master;

  localparam int unsigned MEM_WORDS = 65536;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [31:0] mem_read_address;
  logic [31:0] mem_write_address;
  logic        mem_write_enable;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;
`ifdef LSU_PERF_CNT_EN
  logic [31:0] perf_loads;
  logic [31:0] perf_stores;
  logic [31:0] perf_errs;
`endif

  lsu_mem_master dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_we            (req_we),
    .req_addr          (req_addr),
    .req_wdata         (req_wdata),
    .rsp_valid         (rsp_valid),
    .rsp_ready         (rsp_ready),
    .rsp_data          (rsp_data),
    .rsp_err           (rsp_err),
    .mem_read_address  (mem_read_address),
    .mem_write_address (mem_write_address),
    .mem_write_enable  (mem_write_enable),
    .mem_data_in       (mem_data_in),
`ifdef LSU_PERF_CNT_EN
    .perf_loads        (perf_loads),
    .perf_stores       (perf_stores),
    .perf_errs         (perf_errs),
`endif
    .mem_data_out      (mem_data_out)
  );

  always #5 clk = ~clk;

  // Behavioural combinational-read memory, preloaded on the first edge.
  bit [31:0] mem [MEM_WORDS];
  bit        mem_init_done;
  always @(posedge clk) begin
    if (!mem_init_done) begin
      mem[3]        <= 32'd7;
      mem[9]        <= 32'd1;
      mem_init_done <= 1'b1;
    end else if (mem_write_enable) begin
      mem[mem_write_address[15:0]] <= mem_data_in;
    end
  end
  assign mem_data_out = (mem_read_address < 32'(MEM_WORDS)) ? mem[mem_read_address[15:0]] : 32'h0;

  typedef struct packed { logic [31:0] data; logic err; } exp_t;
  typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;

  exp_t        exp_q[$];
  wr_t         wr_q[$];
  bit   [31:0] ref_mem [MEM_WORDS];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          bp_mode = 0;
  int          m_loads = 0;
  int          m_stores = 0;
  int          m_errs = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Response backpressure: 0 always ready, 1 random, 2 held low.
  always @(posedge clk) begin
    #1;
    case (bp_mode)
      0:       rsp_ready = 1'b1;
      1:       rsp_ready = 1'($urandom_range(0, 1));
      default: rsp_ready = 1'b0;
    endcase
  end

  // Monitor: compares responses and write strobes against the queued expectations.
  logic        prev_hold;
  logic [31:0] prev_data;
  logic        prev_err;
  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (mem_write_enable) begin
        if (wr_q.size() == 0) fail_now("unexpected_write_strobe");
        else begin
          wr_t w;
          w = wr_q.pop_front();
          check("wr_addr", mem_write_address, w.addr);
          check("wr_data", mem_data_in, w.data);
        end
      end
      if (rsp_valid && req_ready) fail_now("req_ready_during_response");
      if (prev_hold) begin
        check("rsp_valid_held", 32'(rsp_valid), 32'd1);
        check("rsp_data_stable", rsp_data, prev_data);
        check("rsp_err_stable", 32'(rsp_err), 32'(prev_err));
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) fail_now("unexpected_response");
        else begin
          exp_t e;
          e = exp_q.pop_front();
          check("rsp_data", rsp_data, e.data);
          check("rsp_err", 32'(rsp_err), 32'(e.err));
        end
      end
      prev_hold = rsp_valid && !rsp_ready;
      prev_data = rsp_data;
      prev_err  = rsp_err;
    end
  end

  // Issue one request, wait for acceptance, record the expected outcome.
  // Returns just after the accepting edge.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    int cnt;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    cnt = 0;
    while (!req_ready && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    if (!req_ready) begin
      fail_now("request_accept_timeout");
      req_valid = 1'b0;
      return;
    end
    if (addr > 32'd65535) begin
      exp_q.push_back('{data: 32'h0, err: 1'b1});
      m_errs++;
    end else if (we) begin
      ref_mem[addr[15:0]] = wdata;
      exp_q.push_back('{data: 32'h0, err: 1'b0});
      wr_q.push_back('{addr: addr, data: wdata});
      m_stores++;
    end else begin
      exp_q.push_back('{data: ref_mem[addr[15:0]], err: 1'b0});
      m_loads++;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int cnt;
    cnt = 0;
    while (!(req_ready && exp_q.size() == 0) && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 200) fail_now("drain_timeout");
  endtask

  initial begin
    ref_mem[3] = 32'd7;
    ref_mem[9] = 32'd1;

    repeat (3) @(posedge clk);
    #1;
    check("reset_req_ready", 32'(req_ready), 32'd1);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_data", rsp_data, 32'd0);
    check("reset_rsp_err", 32'(rsp_err), 32'd0);
    check("reset_we", 32'(mem_write_enable), 32'd0);
    check("reset_rd_addr", mem_read_address, 32'd0);
    check("reset_wr_addr", mem_write_address, 32'd0);
    check("reset_data_in", mem_data_in, 32'd0);
    rst = 1'b0;

    // Load latency: response visible after the second edge.
    bp_mode = 0;
    do_req(1'b0, 32'd3, 32'h0);
    check("load_busy_ready", 32'(req_ready), 32'd0);
    check("load_no_early_valid", 32'(rsp_valid), 32'd0);
    check("load_rd_addr", mem_read_address, 32'd3);
    @(posedge clk);
    #1;
    check("load_valid", 32'(rsp_valid), 32'd1);
    check("load_data", rsp_data, 32'd7);
    wait_idle();

    // Store: one-cycle strobe, ack with zero data, then read back.
    do_req(1'b1, 32'd5, 32'hDEADBEEF);
    check("store_we_high", 32'(mem_write_enable), 32'd1);
    check("store_wr_addr", mem_write_address, 32'd5);
    check("store_no_early_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    check("store_we_low", 32'(mem_write_enable), 32'd0);
    check("store_ack_valid", 32'(rsp_valid), 32'd1);
    check("store_ack_data", rsp_data, 32'd0);
    wait_idle();
    do_req(1'b0, 32'd5, 32'h0);
    wait_idle();

    // Out-of-range requests respond after the accepting edge with no memory access.
    do_req(1'b0, 32'd65536, 32'h0);
    check("err_load_valid", 32'(rsp_valid), 32'd1);
    check("err_load_err", 32'(rsp_err), 32'd1);
    check("err_load_data", rsp_data, 32'd0);
    wait_idle();
    do_req(1'b1, 32'hFFFFFFFF, 32'h12345678);
    check("err_store_we", 32'(mem_write_enable), 32'd0);
    check("err_store_err", 32'(rsp_err), 32'd1);
    wait_idle();
    do_req(1'b1, 32'd65535, 32'hCAFEF00D);
    wait_idle();
    do_req(1'b0, 32'd65535, 32'h0);
    wait_idle();
    do_req(1'b0, 32'd0, 32'h0);
    wait_idle();

    // Backpressure: response held stable, a pending request is not accepted.
    bp_mode = 2;
    do_req(1'b0, 32'd9, 32'h0);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'd9;
    req_wdata = 32'h55;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_data", rsp_data, 32'd1);
      check("hold_req_ready", 32'(req_ready), 32'd0);
      check("hold_no_write", 32'(mem_write_enable), 32'd0);
    end
    bp_mode = 0;
    do_req(1'b1, 32'd9, 32'h55);
    wait_idle();
    do_req(1'b0, 32'd9, 32'h0);
    wait_idle();

    // Reset in STORE: strobe drops, pending ack discarded, write already done stands.
    do_req(1'b1, 32'd20, 32'hA5A5_5A5A);
    check("rst_store_we_high", 32'(mem_write_enable), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_store_we_low", 32'(mem_write_enable), 32'd0);
    check("rst_store_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_store_req_ready", 32'(req_ready), 32'd1);
    rst = 1'b0;
    exp_q.delete();
    wr_q.delete();
    m_loads  = 0;
    m_stores = 0;
    m_errs   = 0;
    do_req(1'b0, 32'd20, 32'h0);
    wait_idle();

    // Randomized traffic with random backpressure.
    bp_mode = 1;
    for (int i = 0; i < 300; i++) begin
      int unsigned sel;
      logic [31:0] a;
      sel = $urandom_range(0, 9);
      if (sel < 7)       a = 32'($urandom_range(0, 15));
      else if (sel == 7) a = 32'd65535;
      else if (sel == 8) a = 32'd65536 + 32'($urandom_range(0, 10));
      else               a = 32'($urandom);
      do_req(1'($urandom_range(0, 1)), a, 32'($urandom));
    end
    bp_mode = 0;
    wait_idle();
    repeat (2) @(posedge clk);
    #1;
    check("final_write_queue_empty", 32'(wr_q.size()), 32'd0);

`ifdef LSU_PERF_CNT_EN
    check("perf_loads", perf_loads, 32'(m_loads));
    check("perf_stores", perf_stores, 32'(m_stores));
    check("perf_errs", perf_errs, 32'(m_errs));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
